// File: rtl/regfile_mp.sv
// Multi-read-port register file with optional hardwired zero entry, write bypass,
// per-entry busy scoreboard and a sequential clear engine that zeroes storage.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     ready,
  input  logic                     clr_req,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     busy_set,
  input  logic [ADDR_W-1:0]        busy_addr,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] cnt;
  logic [DEPTH-1:0]  busy;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              run, wr_ok, wr_commit, bs_ok;
  logic [ADDR_W-1:0] ra;
  logic              hit;

  assign run   = (state == RUN);
  assign ready = run;
  // wr_ok drives bypass; wr_commit additionally drops writes racing a clear request
  assign wr_ok     = run && we && !(ZERO_REG != 0 && waddr == '0);
  assign wr_commit = wr_ok && !clr_req;
  assign bs_ok     = run && busy_set && !clr_req && !(ZERO_REG != 0 && busy_addr == '0);

  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (cnt == '1) state_next = RUN;
      RUN:     if (clr_req) state_next = CLEAR;
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_next;
      if (state == CLEAR) cnt <= cnt + 1'b1;
      else                cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else if (run) begin
      if (clr_req) begin
        busy <= '0;
      end else begin
        if (wr_commit) busy[waddr]     <= 1'b0;
        if (bs_ok)     busy[busy_addr] <= 1'b1;
      end
    end
  end

  // Storage has no reset; the clear sweep zeroes it before any read is allowed
  always_ff @(posedge clk) begin
    if (!run)           mem[cnt]   <= '0;
    else if (wr_commit) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata = '0;
    rbusy = '0;
    ra    = '0;
    hit   = 1'b0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      ra  = raddr[k*ADDR_W +: ADDR_W];
      hit = (BYPASS != 0) && wr_ok && (waddr == ra);
      if (run && re[k] && !(ZERO_REG != 0 && ra == '0)) begin
        rdata[k*DATA_W +: DATA_W] = hit ? wdata : mem[ra];
        rbusy[k]                  = busy[ra] && !hit;
      end
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp: two instances (bypass on/off)
// checked every cycle against a behavioural model, plus literal expectations.
module tb_regfile_mp;
  localparam int DW = 32, AW = 5, NR = 4, DEPTH = 32;

  logic          clk = 1'b0, rst_n = 1'b1;
  logic          clr_req = 1'b0, we = 1'b0, busy_set = 1'b0;
  logic [AW-1:0] waddr = '0, busy_addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [NR-1:0] re = '0;
  logic [NR*AW-1:0] raddr = '0;

  logic             ready_b, ready_n;
  logic [NR*DW-1:0] rdata_b, rdata_n;
  logic [NR-1:0]    rbusy_b, rbusy_n;

  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .ready(ready_b), .clr_req(clr_req), .we(we),
    .waddr(waddr), .wdata(wdata), .busy_set(busy_set), .busy_addr(busy_addr),
    .re(re), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b));

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .ready(ready_n), .clr_req(clr_req), .we(we),
    .waddr(waddr), .wdata(wdata), .busy_set(busy_set), .busy_addr(busy_addr),
    .re(re), .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: remaining clear cycles, array contents, busy bits
  logic [DW-1:0]    m_mem [DEPTH];
  logic [DEPTH-1:0] m_busy = '0;
  int               m_left = DEPTH;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = DEPTH;
      m_busy = '0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    end else if (clr_req) begin
      m_left = DEPTH;
      m_busy = '0;
    end else begin
      if (we && waddr != 0) begin
        m_mem[waddr]  = wdata;
        m_busy[waddr] = 1'b0;
      end
      if (busy_set && busy_addr != 0) m_busy[busy_addr] = 1'b1;
    end
  end

  function automatic void model_port(input bit byp, input int k,
                                     output logic [DW-1:0] d, output logic b);
    logic [AW-1:0] a;
    bit hit;
    a = raddr[k*AW +: AW];
    d = '0;
    b = 1'b0;
    if (m_left == 0 && re[k] && a != 0) begin
      hit = byp && we && (waddr == a);
      d   = hit ? wdata : m_mem[a];
      b   = m_busy[a] && !hit;
    end
  endfunction

  always @(negedge clk) begin
    logic [DW-1:0] d;
    logic b;
    chk("ready_byp", ready_b, m_left == 0);
    chk("ready_nobyp", ready_n, m_left == 0);
    for (int k = 0; k < NR; k++) begin
      model_port(1'b1, k, d, b);
      chk($sformatf("rdata_byp[%0d]", k), rdata_b[k*DW +: DW], d);
      chk($sformatf("rbusy_byp[%0d]", k), rbusy_b[k], b);
      model_port(1'b0, k, d, b);
      chk($sformatf("rdata_nobyp[%0d]", k), rdata_n[k*DW +: DW], d);
      chk($sformatf("rbusy_nobyp[%0d]", k), rbusy_n[k], b);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    we = 1'b0; busy_set = 1'b0; clr_req = 1'b0; re = '0;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    raddr[k*AW +: AW] = a;
    re[k] = 1'b1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready_b && n < 200) begin
      tick;
      n++;
    end
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    return ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, DEPTH-1)) : AW'($urandom_range(0, 7));
  endfunction

  initial begin
    int n;
    logic [DW-1:0] exp4 [NR];
    #1 rst_n = 1'b0;
    repeat (3) tick;
    rst_n = 1'b1;
    wait_ready(n);
    chk("sweep_after_reset", n, 32);

    for (int a = 0; a < DEPTH; a += 4) begin
      idle;
      for (int k = 0; k < NR; k++) set_rd(k, AW'(a + k));
      @(negedge clk);
      chk("zero_after_sweep", rdata_b, '0);
      chk("busy_after_sweep", rbusy_b, '0);
      tick;
    end

    idle; we = 1'b1; waddr = 5; wdata = 32'hDEADBEEF; set_rd(0, 5);
    @(negedge clk);
    chk("bypass_same_cycle", rdata_b[31:0], 32'hDEADBEEF);
    chk("nobypass_same_cycle", rdata_n[31:0], 32'h0);
    tick; we = 1'b0;
    @(negedge clk);
    chk("nobypass_next_cycle", rdata_n[31:0], 32'hDEADBEEF);
    tick;

    idle; we = 1'b1; waddr = 0; wdata = 32'h12345678; busy_set = 1'b1; busy_addr = 0; set_rd(0, 0);
    @(negedge clk);
    chk("r0_write_cycle", rdata_b[31:0], 32'h0);
    tick; idle; set_rd(0, 0);
    @(negedge clk);
    chk("r0_read_zero", rdata_n[31:0], 32'h0);
    chk("r0_never_busy", rbusy_b[0], 1'b0);
    tick;

    idle; busy_set = 1'b1; busy_addr = 7;
    tick; idle; set_rd(0, 7);
    @(negedge clk);
    chk("r7_busy_set", rbusy_b[0], 1'b1);
    tick; we = 1'b1; waddr = 7; wdata = 32'h77; busy_set = 1'b1; busy_addr = 7;
    @(negedge clk);
    chk("r7_busy_nobyp_during_write", rbusy_n[0], 1'b1);
    tick; we = 1'b0; busy_set = 1'b0;
    @(negedge clk);
    chk("r7_new_producer_wins", rbusy_b[0], 1'b1);
    tick; we = 1'b1; waddr = 7; wdata = 32'h99;
    @(negedge clk);
    chk("r7_bypass_masks_busy", rbusy_b[0], 1'b0);
    chk("r7_nobyp_still_busy", rbusy_n[0], 1'b1);
    tick; we = 1'b0;
    @(negedge clk);
    chk("r7_busy_cleared", rbusy_n[0], 1'b0);
    tick;

    idle; we = 1'b1; waddr = 3; wdata = 32'hA;
    tick; waddr = 9; wdata = 32'hB;
    tick; idle;
    set_rd(0, 3); set_rd(1, 3); set_rd(2, 9); set_rd(3, 0);
    exp4 = '{32'hA, 32'hA, 32'hB, 32'h0};
    @(negedge clk);
    for (int k = 0; k < NR; k++) chk($sformatf("four_port[%0d]", k), rdata_n[k*DW +: DW], exp4[k]);
    tick; re = 4'b0101;
    exp4 = '{32'hA, 32'h0, 32'hB, 32'h0};
    @(negedge clk);
    for (int k = 0; k < NR; k++) chk($sformatf("four_port_re0101[%0d]", k), rdata_b[k*DW +: DW], exp4[k]);
    tick;

    idle; busy_set = 1'b1; busy_addr = 4;
    tick; idle; clr_req = 1'b1;
    tick; clr_req = 1'b0;
    wait_ready(n);
    chk("sweep_after_clr_req", n, 32);
    idle; set_rd(0, 3); set_rd(1, 4); set_rd(2, 9); set_rd(3, 5);
    @(negedge clk);
    chk("data_cleared", rdata_b, '0);
    chk("busy_cleared", rbusy_b, '0);
    tick;

    idle; clr_req = 1'b1;
    tick; clr_req = 1'b0;
    repeat (10) tick;
    rst_n = 1'b0;
    tick; tick;
    rst_n = 1'b1;
    wait_ready(n);
    chk("sweep_restart_after_reset", n, 32);

    repeat (3000) begin
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        tick; tick;
        rst_n = 1'b1;
      end
      clr_req   = ($urandom_range(0, 199) == 0);
      we        = $urandom_range(0, 1);
      waddr     = rnd_addr();
      wdata     = $urandom;
      busy_set  = ($urandom_range(0, 2) == 0);
      busy_addr = rnd_addr();
      re        = NR'($urandom);
      for (int k = 0; k < NR; k++) raddr[k*AW +: AW] = rnd_addr();
      tick;
    end

    idle;
    tick;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the CPU decode/writeback stage, the successor to the fixed 32x32 two-port file. Adds a configurable hardwired-zero entry, write-to-read bypass, a per-entry busy scoreboard for in-flight producers, and a sequential clear engine. The clear engine zeroes storage after reset or on request, so the storage array needs no reset. The pipeline issues reads and writes only while `ready` is high.

## Interface
- `DATA_W`, 32, register width in bits
- `ADDR_W`, 5, address width; `DEPTH` = 2**ADDR_W entries
- `NUM_RD`, 2, number of read ports (1..4)
- `ZERO_REG`, 1, when 1 entry 0 reads as zero, ignores writes and never goes busy
- `BYPASS`, 1, when 1 same-cycle write data is forwarded to matching reads
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `ready`  out  1  high when the file accepts reads, writes and busy updates
- `clr_req`  in  1  single-cycle pulse that starts a full clear sweep
- `we`  in  1  write enable
- `waddr`  in  ADDR_W  write address
- `wdata`  in  DATA_W  write data
- `busy_set`  in  1  mark `busy_addr` as awaiting writeback
- `busy_addr`  in  ADDR_W  scoreboard address
- `re`  in  NUM_RD  per-port read enable
- `raddr`  in  NUM_RD*ADDR_W  packed read addresses; port k is at bits [k*ADDR_W +: ADDR_W]
- `rdata`  out  NUM_RD*DATA_W  packed read data (combinational)
- `rbusy`  out  NUM_RD  per-port busy flag for the addressed entry (combinational)

## Operation
- FSM states: CLEAR and RUN.
- Reset (`rst_n`=0, asynchronous): state=CLEAR, clear counter=0, all busy bits=0, `ready`=0. Storage is not reset.
- CLEAR:
  - Each cycle writes 0 to entry[counter], then increments the counter.
  - On the cycle the counter equals DEPTH-1, that write occurs and the next state is RUN.
  - `we`, `busy_set` and `clr_req` are ignored. `rdata`=0 and `rbusy`=0 on all ports.
- RUN:
  - `ready`=1.
  - `clr_req`=1 moves to CLEAR next cycle, with counter=0 and all busy bits cleared on the same edge.
  - A write presented in the same cycle as `clr_req` is discarded.
- Write: if `we` is high, entry[waddr] takes `wdata` at the edge. Exception: if ZERO_REG=1 and `waddr`=0, the write is dropped.
- Read port k:
  - `re[k]`=0 gives rdata_k=0.
  - If ZERO_REG=1 and raddr_k=0, rdata_k=0.
  - Otherwise, if BYPASS=1, `we`=1 and `waddr`=raddr_k (and the write is not dropped), rdata_k=`wdata`.
  - Otherwise rdata_k=entry[raddr_k].
- Scoreboard:
  - `busy_set` sets busy[busy_addr] at the edge. Ignored for address 0 when ZERO_REG=1.
  - A non-dropped write clears busy[waddr] at the edge.
  - If `busy_set` and a write target the same address in one cycle, the bit ends up set (the new producer wins).
- rbusy_k = `re[k]` & busy[raddr_k].
  - With BYPASS=1, it is additionally masked to 0 when a same-cycle non-dropped write targets raddr_k.
  - Always 0 for address 0 when ZERO_REG=1.
- All read ports are independent; any ports may address the same entry.

## Timing
- Clear sweep: exactly DEPTH cycles in CLEAR. `ready` rises on the first edge after the DEPTH-th clear write.
  - Default: `ready` is high in the cycle DEPTH after reset release or after the `clr_req` edge.
- Write-to-read latency: 0 cycles with BYPASS=1; 1 cycle (next cycle) with BYPASS=0.
- Scoreboard latency: busy is visible on `rbusy` the cycle after `busy_set`; the write clear takes effect as described above.
- Reset asserted mid-sweep or mid-RUN: immediate return to CLEAR with counter=0 and the sweep restarts. Partially written storage is irrelevant because the full sweep re-zeroes it.
- Output values under reset: `ready`=0, `rdata`=0, `rbusy`=0.

## Test plan
- Reset release -> `ready`=0 for 32 cycles, then 1. Read of every address returns 0, with `rbusy`=0.
- RUN, write 0xDEADBEEF to r5 with port 0 reading r5 in the same cycle -> BYPASS=1 gives 0xDEADBEEF that cycle; BYPASS=0 gives 0 that cycle and 0xDEADBEEF the next.
- Write 0x12345678 to r0 with ZERO_REG=1 -> reads of r0 stay 0; `busy_set` on r0 leaves `rbusy`=0.
- `busy_set` r7 -> `rbusy`=1 next cycle. A write to r7 with a simultaneous `busy_set` r7 keeps it 1. A later plain write to r7 clears it, and with BYPASS=1 `rbusy` shows 0 in the write cycle.
- NUM_RD=4, all ports reading r3, r3, r9, r0 after writes r3=0xA, r9=0xB -> rdata = 0xA, 0xA, 0xB, 0. Same read with `re`=4'b0101 -> 0xA, 0, 0xB, 0.
- `clr_req` in RUN with busy r4 and data present -> `ready` low for 32 cycles, all data 0, busy cleared. Assert `rst_n`=0 in sweep cycle 10 -> the sweep restarts and `ready` is delayed a further full 32 cycles after release.
